// File: rtl/traf_ctl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : traf_ctl_fsm
// Purpose  : Intersection phase controller driving the NS/EW countdown timers,
//            lamps, pedestrian walk lamp and night flashing mode.
// Revision : 1.0  initial release
// ============================================================================
module traf_ctl_fsm #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Done_NS,
    input  logic       Done_EW,
    input  logic       Ped_Req,
    input  logic       Night,
    output logic       Ld,
    output logic       En,
    output logic [3:0] State,
    output logic [2:0] Light_NS,
    output logic [2:0] Light_EW,
    output logic       Ped_Walk
);

    localparam int              CNT_W       = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] c_TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [2:0]      c_RED       = 3'b100;
    localparam logic [2:0]      c_YEL       = 3'b010;
    localparam logic [2:0]      c_GRN       = 3'b001;

    typedef enum logic [2:0] {
        S_NSG   = 3'd0,
        S_NSY   = 3'd1,
        S_EWG   = 3'd2,
        S_EWY   = 3'd3,
        S_FLASH = 3'd4
    } phase_t;

    phase_t           r_phase;
    logic [CNT_W-1:0] r_presc;
    logic             r_ped;
    logic             r_flash;
    logic             r_night;
    logic             r_init;
    logic             r_entry;

    phase_t           w_next;
    logic             w_tick;
    logic             w_entry;
    logic             w_ewg_entry;
    logic             w_flash_next;
    logic [CNT_W-1:0] w_presc_next;

    function automatic logic [3:0] state_code(input phase_t p);
        case (p)
            S_NSG:   return 4'b0010;
            S_NSY:   return 4'b0100;
            S_FLASH: return 4'b1000;
            default: return 4'b0001;
        endcase
    endfunction

    function automatic phase_t next_phase(input phase_t p, input logic dns,
                                          input logic dew, input logic tick,
                                          input logic night);
        case (p)
            S_NSG:   return dns ? S_NSY : S_NSG;
            S_NSY:   return dns ? (night ? S_FLASH : S_EWG) : S_NSY;
            S_EWG:   return dew ? S_EWY : S_EWG;
            S_EWY:   return dns ? (night ? S_FLASH : S_NSG) : S_EWY;
            S_FLASH: return (tick && !night) ? S_NSG : S_FLASH;
            default: return S_NSG;
        endcase
    endfunction

    assign w_tick       = (r_presc == c_TICK_LAST);
    assign w_next       = next_phase(r_phase, Done_NS, Done_EW, w_tick, r_night);
    // EWG and EWY share the St0 code, so that hop is not a phase entry
    assign w_entry      = (state_code(w_next) != state_code(r_phase));
    assign w_ewg_entry  = (w_next == S_EWG) && (r_phase != S_EWG);
    assign w_presc_next = (r_entry || w_tick) ? '0 : r_presc + CNT_W'(1);
    assign w_flash_next = (r_phase != S_FLASH) ? 1'b1 : (r_flash ^ w_tick);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_phase  <= S_NSG;
            r_presc  <= '0;
            r_ped    <= 1'b0;
            r_flash  <= 1'b0;
            r_night  <= 1'b0;
            r_init   <= 1'b1;
            r_entry  <= 1'b0;
            State    <= 4'b0010;
            Ld       <= 1'b0;
            En       <= 1'b0;
            Light_NS <= c_GRN;
            Light_EW <= c_RED;
            Ped_Walk <= 1'b0;
        end else begin
            r_night <= Night;
            r_init  <= 1'b0;
            r_entry <= w_entry | r_init;
            r_phase <= w_next;
            r_presc <= w_presc_next;
            State   <= state_code(w_next);
            // FLASH holds Ld so both timers stay pinned at zero
            Ld      <= w_entry | r_init | (w_next == S_FLASH);
            En      <= (w_presc_next == c_TICK_LAST) && (w_next != S_FLASH)
                       && !w_entry && !r_init;
            if (w_next == S_FLASH)
                r_flash <= w_flash_next;

            case (w_next)
                S_NSG: begin
                    Light_NS <= c_GRN;
                    Light_EW <= c_RED;
                end
                S_NSY: begin
                    Light_NS <= c_YEL;
                    Light_EW <= c_RED;
                end
                S_EWG: begin
                    Light_NS <= c_RED;
                    Light_EW <= c_GRN;
                end
                S_EWY: begin
                    Light_NS <= c_RED;
                    Light_EW <= c_YEL;
                end
                default: begin
                    Light_NS <= {1'b0, w_flash_next, 1'b0};
                    Light_EW <= {w_flash_next, 2'b00};
                end
            endcase

            // A request on the EWG-entry edge is served immediately
            if (w_ewg_entry) begin
                Ped_Walk <= r_ped | Ped_Req;
                r_ped    <= 1'b0;
            end else begin
                if (w_next != S_EWG)
                    Ped_Walk <= 1'b0;
                if (Ped_Req && (r_phase != S_FLASH))
                    r_ped <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_traf_ctl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_traf_ctl_fsm
// Purpose  : Vector-table bench for traf_ctl_fsm with TICK_DIV=4.
// Revision : 1.0  initial release
// ============================================================================
module tb_traf_ctl_fsm;

    localparam int TD = 4;

    localparam logic [3:0] ST_NSG = 4'b0010;
    localparam logic [3:0] ST_NSY = 4'b0100;
    localparam logic [3:0] ST_EW  = 4'b0001;
    localparam logic [3:0] ST_FL  = 4'b1000;

    typedef struct {
        logic        dns;
        logic        dew;
        logic        ped;
        logic        night;
        logic [12:0] exp;   // {State, Ld, En, Light_NS, Light_EW, Ped_Walk}
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       done_ns, done_ew, ped_req, night;
    logic       ld, en, ped_walk;
    logic [3:0] state;
    logic [2:0] light_ns, light_ew;

    vec_t        tbl[$];
    logic [12:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    traf_ctl_fsm #(.TICK_DIV(TD)) dut (
        .Clk     (clk),
        .Reset   (rst),
        .Done_NS (done_ns),
        .Done_EW (done_ew),
        .Ped_Req (ped_req),
        .Night   (night),
        .Ld      (ld),
        .En      (en),
        .State   (state),
        .Light_NS(light_ns),
        .Light_EW(light_ew),
        .Ped_Walk(ped_walk)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] pk(input logic [3:0] st, input logic l,
                                       input logic e, input logic [2:0] ns,
                                       input logic [2:0] ew, input logic w);
        return {st, l, e, ns, ew, w};
    endfunction

    function automatic logic [12:0] outs();
        return {state, ld, en, light_ns, light_ew, ped_walk};
    endfunction

    task automatic chk(input string name, input logic [12:0] got, input logic [12:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b ({State,Ld,En,NS,EW,Walk})", name, got, exp);
        end
    endtask

    task automatic add_vec(input logic dns, input logic dew, input logic pr,
                           input logic ni, input logic [12:0] e);
        vec_t v;
        v.dns = dns; v.dew = dew; v.ped = pr; v.night = ni; v.exp = e;
        tbl.push_back(v);
    endtask

    // Entry cycle, then gap cycles with the tick on the last one.
    // Mid-phase inputs (m*) are applied on the first cycle after entry.
    task automatic add_phase(input logic dns, input logic dew, input logic pe,
                             input logic ni, input logic [3:0] st, input logic l,
                             input logic [2:0] ns, input logic [2:0] ew,
                             input logic w, input int gap, input logic mdns,
                             input logic mdew, input logic mped);
        add_vec(dns, dew, pe, ni, pk(st, l, 1'b0, ns, ew, w));
        for (int j = 1; j <= gap; j++)
            add_vec((j == 1) && mdns, (j == 1) && mdew, (j == 1) && mped, ni,
                    pk(st, 1'b0, j == gap, ns, ew, w));
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            logic [12:0] e;
            done_ns = tbl[i].dns;
            done_ew = tbl[i].dew;
            ped_req = tbl[i].ped;
            night   = tbl[i].night;
            exp_q.push_back(tbl[i].exp);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            chk($sformatf("%s[%0d]", tag, i), outs(), e);
            @(negedge clk);
        end
        tbl.delete();
    endtask

    initial begin
        rst = 1'b1; done_ns = 1'b0; done_ew = 1'b0; ped_req = 1'b0; night = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", outs(), pk(ST_NSG, 1'b0, 1'b0, 3'b001, 3'b100, 1'b0));
        rst = 1'b0;

        // Init load, request in NSG, ignored/simultaneous Done inputs
        add_phase(0,0,0,0, ST_NSG,1, 3'b001,3'b100,0, TD,   0,0,1);
        add_phase(1,0,0,0, ST_NSY,1, 3'b010,3'b100,0, TD,   0,1,0);
        add_phase(1,0,0,0, ST_EW, 1, 3'b100,3'b001,1, TD,   1,0,0);
        add_phase(1,1,0,0, ST_EW, 0, 3'b100,3'b010,0, TD-1, 0,0,0);
        // No request; request during EWG stays pending
        add_phase(1,0,0,0, ST_NSG,1, 3'b001,3'b100,0, TD,   0,0,0);
        add_phase(1,0,0,0, ST_NSY,1, 3'b010,3'b100,0, TD,   0,0,0);
        add_phase(1,0,0,0, ST_EW, 1, 3'b100,3'b001,0, TD,   0,0,1);
        add_phase(0,1,0,0, ST_EW, 0, 3'b100,3'b010,0, TD-1, 0,0,0);
        add_phase(1,0,0,0, ST_NSG,1, 3'b001,3'b100,0, TD,   0,0,0);
        add_phase(1,0,0,0, ST_NSY,1, 3'b010,3'b100,0, TD,   0,0,0);
        add_phase(1,0,0,0, ST_EW, 1, 3'b100,3'b001,1, TD,   0,0,0);
        add_phase(0,1,0,0, ST_EW, 0, 3'b100,3'b010,0, TD-1, 0,0,0);
        // Request on the EWG-entry edge: served now, not again next time
        add_phase(1,0,0,0, ST_NSG,1, 3'b001,3'b100,0, TD,   0,0,0);
        add_phase(1,0,0,0, ST_NSY,1, 3'b010,3'b100,0, TD,   0,0,0);
        add_phase(1,0,1,0, ST_EW, 1, 3'b100,3'b001,1, TD,   0,0,0);
        add_phase(0,1,0,0, ST_EW, 0, 3'b100,3'b010,0, TD-1, 0,0,0);
        add_phase(1,0,0,0, ST_NSG,1, 3'b001,3'b100,0, TD,   0,0,0);
        add_phase(1,0,0,0, ST_NSY,1, 3'b010,3'b100,0, TD,   0,0,0);
        add_phase(1,0,0,0, ST_EW, 1, 3'b100,3'b001,0, TD,   0,0,0);
        add_phase(0,1,0,0, ST_EW, 0, 3'b100,3'b010,0, TD-1, 0,0,0);
        // Night: NSG -> NSY -> FLASH
        add_phase(1,0,0,1, ST_NSG,1, 3'b001,3'b100,0, TD,   0,0,0);
        add_phase(1,0,0,1, ST_NSY,1, 3'b010,3'b100,0, TD,   0,0,0);
        add_vec(1,0,0,1, pk(ST_FL,1,0, 3'b010,3'b100,0));
        for (int j = 1; j <= TD; j++)
            add_vec(j == 2, 0, 0, 1, pk(ST_FL,1,0, 3'b010,3'b100,0));
        for (int j = 1; j <= TD; j++)
            add_vec(0, 0, 0, j == 1, pk(ST_FL,1,0, 3'b000,3'b000,0));
        // Leave FLASH on the tick, then set up EWG with walk for the reset test
        add_phase(0,0,0,0, ST_NSG,1, 3'b001,3'b100,0, TD,   0,0,1);
        add_phase(1,0,0,0, ST_NSY,1, 3'b010,3'b100,0, TD,   0,0,0);
        add_phase(1,0,0,0, ST_EW, 1, 3'b100,3'b001,1, TD,   0,0,0);
        run_table("main");

        // Asynchronous reset mid-cycle with Ped_Walk set
        done_ns = 1'b0; done_ew = 1'b0; ped_req = 1'b0; night = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_reset_walk", outs(), pk(ST_EW, 1'b0, 1'b0, 3'b100, 3'b001, 1'b1));
        #2 rst = 1'b1;
        #1;
        chk("async_reset", outs(), pk(ST_NSG, 1'b0, 1'b0, 3'b001, 3'b100, 1'b0));
        @(negedge clk);
        rst = 1'b0;
        add_phase(0,0,0,0, ST_NSG,1, 3'b001,3'b100,0, TD,   0,0,0);
        add_phase(1,0,0,0, ST_NSY,1, 3'b010,3'b100,0, TD,   0,0,0);
        run_table("reinit");

        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
